// File: rtl/instr_decode_unit.sv
// rtl/instr_decode_unit.sv - state/IR control decoder for the relay computer
module instr_decode_unit #(
   parameter int NREG = 8
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [4:0]      seq_state,
   input  logic            state_valid,
   input  logic [7:0]      data_in,
   input  logic            flag_z,
   input  logic            flag_c,
   input  logic            flag_s,
   output logic [7:0]      ir,
   output logic [NREG-1:0] sel_reg,
   output logic [NREG-1:0] ld_reg,
   output logic            sel_pc,
   output logic            ld_pc,
   output logic            sel_inc,
   output logic            ld_inc,
   output logic            sel_j,
   output logic            ld_j,
   output logic            mem_rd,
   output logic            mem_wr,
   output logic            alu_en,
   output logic            ld_imm,
   output logic [3:0]      abort,
   output logic            halt
);

   localparam logic [NREG-1:0] PAIR_M = NREG'(3) << 4;
   localparam logic [NREG-1:0] PAIR_XY = NREG'(3) << 6;

   function automatic logic [NREG-1:0] onehot(input logic [2:0] idx);
      return NREG'(1) << idx;
   endfunction

   logic [NREG-1:0] n_sel_reg, n_ld_reg;
   logic            n_sel_pc, n_ld_pc, n_sel_inc, n_ld_inc, n_sel_j, n_ld_j;
   logic            n_mem_rd, n_mem_wr, n_alu_en, n_ld_imm, n_halt_set;
   logic [3:0]      n_abort;
   logic            taken_q, taken_now;
   logic [4:0]      st;

   assign st = seq_state;
   assign taken_now = (ir[4] & flag_s) | (ir[3] & flag_c) | (ir[2] & flag_z)
                    | (ir[1] & ~flag_z) | (ir[4:1] == 4'b0000);

   always_comb begin
      n_sel_reg  = '0;
      n_ld_reg   = '0;
      n_sel_pc   = (st <= 5'd2);
      n_mem_rd   = (st <= 5'd2);
      n_ld_inc   = (st == 5'd1);
      n_sel_inc  = (st == 5'd4) || (st == 5'd5);
      n_ld_pc    = (st == 5'd5);
      n_sel_j    = 1'b0;
      n_ld_j     = 1'b0;
      n_mem_wr   = 1'b0;
      n_alu_en   = 1'b0;
      n_ld_imm   = 1'b0;
      n_halt_set = 1'b0;
      n_abort    = 4'b0000;
      // abort is decoded one state early so it is visible while the
      // sequencer presents the final state (8/10/12/14)
      if (ir[7:6] == 2'b00) begin
         if (st == 5'd4 || st == 5'd5) n_sel_reg = onehot(ir[2:0]);
         if (st == 5'd5) n_ld_reg = onehot(ir[5:3]);
         if (st == 5'd7) n_abort = 4'b0001;
      end else if (ir[7:6] == 2'b01) begin
         n_ld_imm = (st == 5'd4) || (st == 5'd5);
         if (st == 5'd5) n_ld_reg = onehot(ir[5] ? 3'd1 : 3'd0);
         if (st == 5'd7) n_abort = 4'b0001;
      end else if (ir[7:4] == 4'b1000) begin
         n_alu_en = (st == 5'd4) || (st == 5'd5);
         if (st == 5'd5) n_ld_reg = onehot(ir[3] ? 3'd3 : 3'd0);
         if (st == 5'd7) n_abort = 4'b0001;
      end else if (ir == 8'hAE) begin
         n_halt_set = (st == 5'd4);
         if (st == 5'd7) n_abort = 4'b0001;
      end else if (ir[7:4] == 4'b1010) begin
         if (st == 5'd8 || st == 5'd9) n_sel_reg = ir[2] ? PAIR_XY : PAIR_M;
         if (st == 5'd9) n_ld_reg = ir[3] ? PAIR_XY : PAIR_M;
         if (st == 5'd9) n_abort = 4'b0010;
      end else if (ir[7:2] == 6'b100100) begin
         if (st inside {[5'd8:5'd11]}) begin
            n_sel_reg = PAIR_M;
            n_mem_rd  = 1'b1;
         end
         if (st == 5'd10) n_ld_reg = onehot({1'b0, ir[1:0]});
         if (st == 5'd11) n_abort = 4'b0100;
      end else if (ir[7:2] == 6'b100110) begin
         if (st inside {[5'd8:5'd11]}) n_sel_reg = PAIR_M | onehot({1'b0, ir[1:0]});
         n_mem_wr = (st == 5'd10);
         if (st == 5'd11) n_abort = 4'b0100;
      end else if (ir == 8'hB0) begin
         if (st == 5'd8 || st == 5'd9) n_sel_reg = PAIR_XY;
         if (st == 5'd9) n_ld_inc = 1'b1;
         if (st == 5'd12 || st == 5'd13) n_sel_inc = 1'b1;
         if (st == 5'd13) n_ld_reg = PAIR_XY;
         if (st == 5'd13) n_abort = 4'b1000;
      end else if (ir[7:6] == 2'b11 && !ir[0]) begin
         if (st inside {[5'd8:5'd15]}) begin
            n_sel_reg = PAIR_M;
            n_mem_rd  = 1'b1;
         end
         n_ld_j = (st == 5'd15);
         // return address PC+3 comes off the incrementer into XY
         if (ir[5] && (st == 5'd18 || st == 5'd19)) n_sel_inc = 1'b1;
         if (ir[5] && st == 5'd19) n_ld_reg = PAIR_XY;
         if (taken_q && (st == 5'd21 || st == 5'd22)) n_sel_j = 1'b1;
         if (taken_q && st == 5'd22) n_ld_pc = 1'b1;
      end else begin
         if (st == 5'd7) n_abort = 4'b0001;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ir      <= 8'h00;
         halt    <= 1'b0;
         taken_q <= 1'b0;
         sel_reg <= '0;
         ld_reg  <= '0;
         sel_pc  <= 1'b0;
         ld_pc   <= 1'b0;
         sel_inc <= 1'b0;
         ld_inc  <= 1'b0;
         sel_j   <= 1'b0;
         ld_j    <= 1'b0;
         mem_rd  <= 1'b0;
         mem_wr  <= 1'b0;
         alu_en  <= 1'b0;
         ld_imm  <= 1'b0;
         abort   <= 4'b0000;
      end else if (state_valid) begin
         if (st == 5'd2) ir <= data_in;
         if (n_halt_set) halt <= 1'b1;
         if (st == 5'd16) taken_q <= taken_now;
         sel_reg <= n_sel_reg;
         ld_reg  <= n_ld_reg;
         sel_pc  <= n_sel_pc;
         ld_pc   <= n_ld_pc;
         sel_inc <= n_sel_inc;
         ld_inc  <= n_ld_inc;
         sel_j   <= n_sel_j;
         ld_j    <= n_ld_j;
         mem_rd  <= n_mem_rd;
         mem_wr  <= n_mem_wr;
         alu_en  <= n_alu_en;
         ld_imm  <= n_ld_imm;
         abort   <= n_abort;
      end else begin
         sel_reg <= '0;
         ld_reg  <= '0;
         sel_pc  <= 1'b0;
         ld_pc   <= 1'b0;
         sel_inc <= 1'b0;
         ld_inc  <= 1'b0;
         sel_j   <= 1'b0;
         ld_j    <= 1'b0;
         mem_rd  <= 1'b0;
         mem_wr  <= 1'b0;
         alu_en  <= 1'b0;
         ld_imm  <= 1'b0;
         abort   <= 4'b0000;
      end
   end

endmodule

// File: tb/tb_instr_decode_unit.sv
// tb/tb_instr_decode_unit.sv - directed-vector bench for instr_decode_unit
module tb_instr_decode_unit;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] seq_state = '0;
   logic       state_valid = 1'b0;
   logic [7:0] data_in = '0;
   logic       flag_z = 1'b0, flag_c = 1'b0, flag_s = 1'b0;
   logic [7:0] ir, sel_reg, ld_reg;
   logic       sel_pc, ld_pc, sel_inc, ld_inc, sel_j, ld_j;
   logic       mem_rd, mem_wr, alu_en, ld_imm, halt;
   logic [3:0] abort;

   instr_decode_unit #(.NREG(8)) dut (
      .clock(clock), .reset(reset), .seq_state(seq_state), .state_valid(state_valid),
      .data_in(data_in), .flag_z(flag_z), .flag_c(flag_c), .flag_s(flag_s),
      .ir(ir), .sel_reg(sel_reg), .ld_reg(ld_reg),
      .sel_pc(sel_pc), .ld_pc(ld_pc), .sel_inc(sel_inc), .ld_inc(ld_inc),
      .sel_j(sel_j), .ld_j(ld_j), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .alu_en(alu_en), .ld_imm(ld_imm), .abort(abort), .halt(halt)
   );

   always #5 clock = ~clock;

   // ctl = {sel_pc, ld_pc, sel_inc, ld_inc, sel_j, ld_j, mem_rd, mem_wr, alu_en, ld_imm}
   typedef struct packed {
      logic [7:0] ir;
      logic [7:0] sel;
      logic [7:0] ld;
      logic [3:0] ab;
      logic [9:0] ctl;
      logic       halt;
   } snap_t;

   localparam logic [9:0] STROBE_MASK = 10'h15F;
   localparam int         CTL_LD_PC = 8, CTL_LD_J = 4, CTL_MEM_RD = 3, CTL_MEM_WR = 2, CTL_ALU = 1;

   snap_t cur;
   snap_t hist [0:24];
   int    n_checks = 0;
   int    n_fail = 0;

   task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one state across a rising edge; cur holds the decode of that state.
   task automatic step(input logic [4:0] st, input logic v, input logic r);
      seq_state = st;
      state_valid = v;
      reset = r;
      @(posedge clock);
      #1;
      cur = '{ir, sel_reg, ld_reg, abort,
              {sel_pc, ld_pc, sel_inc, ld_inc, sel_j, ld_j, mem_rd, mem_wr, alu_en, ld_imm},
              halt};
   endtask

   task automatic run(input logic [7:0] instr, input int last, input logic z16);
      data_in = instr;
      for (int k = 0; k <= last; k++) begin
         flag_z = (k <= 16) ? z16 : ~z16;
         step(5'(k), 1'b1, 1'b0);
         hist[k] = cur;
      end
   endtask

   initial begin
      logic       acc;
      logic [3:0] ab_or;

      step(5'd0, 1'b1, 1'b1);
      step(5'd0, 1'b1, 1'b1);
      expect_eq("reset_all", {cur.ir, cur.sel, cur.ld, cur.ab, cur.ctl, cur.halt}, 0);

      // MOV8 B <- D
      run(8'h0B, 8, 1'b0);
      expect_eq("mov8_ir", hist[2].ir, 8'h0B);
      expect_eq("fetch_selpc_memrd_s0", {hist[0].ctl[9], hist[0].ctl[CTL_MEM_RD]}, 2'b11);
      expect_eq("fetch_ldinc_s1", hist[1].ctl[6], 1);
      expect_eq("mov8_sel_s4", hist[4].sel, 8'h08);
      expect_eq("mov8_sel_s5", hist[5].sel, 8'h08);
      expect_eq("mov8_ld_s4", hist[4].ld, 8'h00);
      expect_eq("mov8_ld_s5", hist[5].ld, 8'h02);
      expect_eq("fetch_ldpc_s5", hist[5].ctl[CTL_LD_PC], 1);
      expect_eq("mov8_abort_at8", hist[7].ab, 4'b0001);
      expect_eq("mov8_abort_off", hist[8].ab, 4'b0000);

      // LOAD C
      run(8'h92, 12, 1'b0);
      acc = 1'b1;
      for (int k = 8; k <= 11; k++) acc &= hist[k].ctl[CTL_MEM_RD];
      expect_eq("load_memrd_8_11", acc, 1);
      expect_eq("load_memrd_12", hist[12].ctl[CTL_MEM_RD], 0);
      expect_eq("load_ld_s10", hist[10].ld, 8'h04);
      expect_eq("load_sel_s9", hist[9].sel, 8'h30);
      expect_eq("load_abort_at8", hist[7].ab, 4'b0000);
      expect_eq("load_abort_at10", hist[9].ab, 4'b0000);
      expect_eq("load_abort_at12", hist[11].ab, 4'b0100);

      // HALT is sticky until reset
      run(8'hAE, 8, 1'b0);
      expect_eq("halt_before", hist[3].halt, 0);
      expect_eq("halt_set", hist[4].halt, 1);
      expect_eq("halt_abort_at8", hist[7].ab, 4'b0001);
      data_in = 8'h00;
      acc = 1'b1;
      for (int k = 0; k < 50; k++) begin
         step(5'(k % 24), 1'b1, 1'b0);
         acc &= cur.halt;
      end
      expect_eq("halt_sticky", acc, 1);
      step(5'd0, 1'b1, 1'b1);
      expect_eq("halt_reset", cur.halt, 0);

      // GOTO z=1 d=1, taken then not taken
      run(8'hE4, 23, 1'b1);
      ab_or = '0;
      for (int k = 0; k <= 23; k++) ab_or |= hist[k].ab;
      expect_eq("goto_t_no_abort", ab_or, 4'b0000);
      expect_eq("goto_t_ldj_s15", hist[15].ctl[CTL_LD_J], 1);
      expect_eq("goto_t_xy_s19", hist[19].ld, 8'hC0);
      expect_eq("goto_t_ldpc_s22", hist[22].ctl[CTL_LD_PC], 1);
      expect_eq("goto_t_ldpc_s21", hist[21].ctl[CTL_LD_PC], 0);
      run(8'hE4, 23, 1'b0);
      ab_or = '0;
      for (int k = 0; k <= 23; k++) ab_or |= hist[k].ab;
      expect_eq("goto_n_no_abort", ab_or, 4'b0000);
      expect_eq("goto_n_xy_s19", hist[19].ld, 8'hC0);
      expect_eq("goto_n_ldpc_s22", hist[22].ctl[CTL_LD_PC], 0);

      // ALU into A: normal, then with a stall at state 5
      run(8'h81, 8, 1'b0);
      expect_eq("alu_ld_s5", hist[5].ld, 8'h01);
      expect_eq("alu_en_s5", hist[5].ctl[CTL_ALU], 1);
      run(8'h81, 4, 1'b0);
      step(5'd5, 1'b0, 1'b0);
      expect_eq("stall_ld", cur.ld, 8'h00);
      expect_eq("stall_strobes", cur.ctl & STROBE_MASK, 10'h000);
      expect_eq("stall_abort", cur.ab, 4'b0000);
      expect_eq("stall_ir", cur.ir, 8'h81);
      data_in = 8'h55;
      step(5'd2, 1'b0, 1'b0);
      expect_eq("stall_ir_no_fetch", cur.ir, 8'h81);

      // STORE A, reset in state 10
      run(8'h98, 9, 1'b0);
      expect_eq("store_sel_s9", hist[9].sel, 8'h31);
      expect_eq("store_memwr_s9", hist[9].ctl[CTL_MEM_WR], 0);
      step(5'd10, 1'b1, 1'b1);
      expect_eq("store_reset_out", {cur.ir, cur.sel, cur.ld, cur.ab, cur.ctl, cur.halt}, 0);
      acc = cur.ctl[CTL_MEM_WR];
      for (int k = 11; k <= 14; k++) begin
         step(5'(k), 1'b1, 1'b0);
         acc |= cur.ctl[CTL_MEM_WR];
      end
      expect_eq("store_no_memwr", acc, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
